fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined CPU: owns the PC, issues addresses
//  to a synchronous instruction ROM, and buffers returned words in a prefetch queue for decode.
//  Adds what the fixed 5-bit fetch path lacks: configurable widths/depth, valid/ready decoupling,
//  redirect (jump) flush with in-flight kill, and a sticky halt. Sits between imem and decode.
// PARAMETERS
//  PC_WIDTH     5   instruction-address width (word addressed; 2**PC_WIDTH words)
//  INSTR_WIDTH  32  instruction word width
//  QUEUE_DEPTH  4   prefetch queue entries; power of two, >= 2
//  RESET_PC     0   PC loaded on reset
// PORTS
//  clk             in   1            system clock; all state updates on rising edge
//  reset           in   1            synchronous, active-high reset
//  imem_addr       out  PC_WIDTH     fetch address (= current PC)
//  imem_req        out  1            address valid this cycle; imem_rdata valid next cycle
//  imem_rdata      in   INSTR_WIDTH  ROM data, exactly 1 cycle after imem_req
//  redirect_valid  in   1            jump taken; pulse
//  redirect_pc     in   PC_WIDTH     jump target
//  halt_req        in   1            halt decoded; pulse
//  out_ready       in   1            decode accepts head entry
//  out_valid       out  1            head entry valid
//  out_instr       out  INSTR_WIDTH  head instruction
//  out_pc          out  PC_WIDTH     address of head instruction
//  halted          out  1            sticky; fetch stopped
//  queue_count     out  $clog2(QUEUE_DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, in-flight=0, halted=0; out_valid=0, imem_req=0, queue_count=0,
//   out_instr/out_pc=0. imem_addr=RESET_PC. Mid-operation reset discards queue and in-flight.
//  Issue: imem_req=1 iff !halted && !reset && (queue_count + inflight) < QUEUE_DEPTH; on issue
//   pc<=pc+1 (mod 2**PC_WIDTH, wraps max->0 silently), inflight<=1 with tag pc.
//  Return: cycle after issue, if in-flight not killed, push {imem_rdata, tag} to queue tail.
//  Dequeue: fire = out_valid && out_ready; head pops. Push+pop same cycle: count unchanged.
//   out_valid = (queue_count != 0); head shown combinationally from queue storage.
//   Full queue never overflows (issue gating guarantees space); pop on empty ignored.
//  Redirect (redirect_valid=1, not halted): same edge pc<=redirect_pc, queue flushed (count=0),
//   in-flight killed (its data dropped next cycle). Issue from redirect_pc starts next cycle;
//   first target instr out_valid 2 cycles after redirect edge. A pop coinciding with redirect is
//   consumed by decode, then flushed state applies.
//  Halt (halt_req=1): halted<=1 sticky until reset; queue flushed, in-flight killed, imem_req=0,
//   out_valid=0 thereafter. halt_req and redirect_valid same cycle: halt wins, pc unchanged.
//   Redirect while halted ignored.
//  Latency: reset deassert -> first out_valid = 2 cycles; steady-state 1 instr/cycle if out_ready=1.
// STRUCTURE
//  Shared header cpu_defs.vh: PC_WIDTH, INSTR_WIDTH, RESET_PC defaults (common to fetch_decode).
//  One sub-module: fetch_queue (sync FIFO, width INSTR_WIDTH+PC_WIDTH, depth QUEUE_DEPTH,
//   push/pop/flush, count, wrap-around pointers). fetch_unit holds pc, inflight, kill, halted.
// TESTING
//  1 Reset, out_ready=1, ROM[i]=i+100 -> out_pc 0,1,2.. one per cycle from cycle 2, instr 100,101..
//  2 out_ready=0 for 10 cycles -> queue_count saturates at 4, imem_req=0, no entry lost; release
//    -> pcs 0..3 then 4 delivered in order.
//  3 redirect_valid with redirect_pc=20 while queue holds 3 -> count=0 next edge, stale in-flight
//    dropped, next out_pc=20 two cycles later, then 21.
//  4 PC_WIDTH=5 from pc=30 -> out_pc 30,31,0,1 (wrap).
//  5 halt_req with redirect_valid same cycle -> halted=1, out_valid=0, imem_req=0 forever; reset
//    -> restart at RESET_PC.
//  6 reset asserted with queue full and in-flight -> next cycle count=0, out_valid=0, no stale push.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared defaults and helpers for the instruction-fetch front end.
//
// Holds the default instruction-address width, instruction width, prefetch
// queue depth and reset PC used by fetch_unit and its prefetch queue, plus a
// helper that sizes occupancy counters for a given queue depth.
package fetch_unit_pkg;

    localparam int DEF_PC_WIDTH    = 5;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_RESET_PC    = 0;

    // A counter for a DEPTH-entry queue must reach DEPTH itself, hence the +1.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {instruction, pc} entries for decode.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; empties the queue
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      empty the queue; a push in the same cycle is discarded
//   head_data  head entry, read combinationally from storage
//   count      number of occupied entries
//
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = DEF_INSTR_WIDTH + DEF_PC_WIDTH,
    parameter int DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [WIDTH-1:0]               head_data,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    assign push_eff  = push && !flush;
    assign pop_eff   = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word addresses to a
// synchronous instruction ROM and buffers the returned words for decode.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   imem_addr       fetch address (current PC)
//   imem_req        address valid this cycle; imem_rdata returns next cycle
//   imem_rdata      ROM data, one cycle after imem_req
//   redirect_valid  taken jump (pulse)
//   redirect_pc     jump target
//   halt_req        halt decoded (pulse); wins over a simultaneous redirect
//   out_ready       decode accepts the head entry
//   out_valid       head entry valid
//   out_instr       head instruction (0 when empty)
//   out_pc          address of head instruction (0 when empty)
//   halted          sticky until reset; fetch stopped
//   queue_count     occupied prefetch-queue entries
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int RESET_PC    = DEF_RESET_PC
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [PC_WIDTH-1:0]           imem_addr,
    output logic                          imem_req,
    input  logic [INSTR_WIDTH-1:0]        imem_rdata,
    input  logic                          redirect_valid,
    input  logic [PC_WIDTH-1:0]           redirect_pc,
    input  logic                          halt_req,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [INSTR_WIDTH-1:0]        out_instr,
    output logic [PC_WIDTH-1:0]           out_pc,
    output logic                          halted,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int CW = count_width(QUEUE_DEPTH);
    localparam int EW = INSTR_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] pc;
    logic                issue_p0;
    logic                redirect_take_p0;
    logic                kill_p0;
    logic [CW:0]         occupancy_p0;
    logic                inflight_p1;
    logic [PC_WIDTH-1:0] tag_p1;
    logic                pop;
    logic [EW-1:0]       head_data;

    // ---- stage p0: issue address to the ROM ----
    // The returning word is counted against free space so a full queue can
    // never be overrun by data already in flight.
    assign occupancy_p0     = {1'b0, queue_count} + (CW + 1)'(inflight_p1);
    assign issue_p0         = !halted && !reset && (occupancy_p0 < (CW + 1)'(QUEUE_DEPTH));
    assign redirect_take_p0 = redirect_valid && !halted && !halt_req;
    assign kill_p0          = halt_req || redirect_take_p0;

    assign imem_addr = pc;
    assign imem_req  = issue_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_WIDTH'(RESET_PC);
            inflight_p1 <= 1'b0;
            halted      <= 1'b0;
        end else if (halt_req) begin
            // PC is held; any request issued this cycle is killed.
            halted      <= 1'b1;
            inflight_p1 <= 1'b0;
        end else if (redirect_take_p0) begin
            // A request issued this cycle targets the old path: drop it.
            pc          <= redirect_pc;
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= issue_p0;
            if (issue_p0) begin
                pc <= pc + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_p0) begin
            tag_p1 <= pc;
        end
    end

    // ---- stage p1: ROM data returns, push into the prefetch queue ----
    // A kill in this cycle flushes the queue, which also discards this push.
    assign pop = out_valid && out_ready;

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_p1),
        .push_data ({imem_rdata, tag_p1}),
        .pop       (pop),
        .flush     (kill_p0),
        .head_data (head_data),
        .count     (queue_count)
    );

    assign out_valid = (queue_count != '0);
    assign out_instr = out_valid ? head_data[EW-1:PC_WIDTH] : '0;
    assign out_pc    = out_valid ? head_data[PC_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int PW = 5;
    localparam int IW = 32;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] imem_addr;
    logic          imem_req;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          halt_req;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic          halted;
    logic [2:0]    queue_count;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .queue_count    (queue_count)
    );

    // Synchronous ROM: word at address a holds a + 100.
    always @(posedge clk) imem_rdata <= IW'(imem_addr) + 32'd100;

    typedef struct {
        bit          first;
        logic        rdy;
        logic        rv;
        logic [4:0]  rpc;
        logic        hr;
        logic        ev;
        logic [4:0]  epc;
        logic [31:0] ei;
        logic [2:0]  ec;
        logic        ereq;
        logic        eh;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input int f, input int rdy, input int rv, input int rpc, input int hr,
                       input int ev, input int epc, input int ei, input int ec,
                       input int ereq, input int eh);
        vec_t v;
        v.first = f[0];
        v.rdy   = rdy[0];
        v.rv    = rv[0];
        v.rpc   = rpc[4:0];
        v.hr    = hr[0];
        v.ev    = ev[0];
        v.epc   = epc[4:0];
        v.ei    = ei;
        v.ec    = ec[2:0];
        v.ereq  = ereq[0];
        v.eh    = eh[0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv,
                         input logic [4:0] rpc, input logic hr);
        reset          = rst;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("rst_valid", -1, 32'(out_valid), 32'd0);
        chk("rst_req",   -1, 32'(imem_req), 32'd0);
        chk("rst_count", -1, 32'(queue_count), 32'd0);
        chk("rst_halted",-1, 32'(halted), 32'd0);
        chk("rst_addr",  -1, 32'(imem_addr), 32'd0);
        chk("rst_pc",    -1, 32'(out_pc), 32'd0);
        chk("rst_instr", -1, out_instr, 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // f rdy rv rpc hr | valid pc instr count req halted
        // Streaming from reset, decode always ready.
        add(1, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  1, 0,100,1,1,0);
        add(0, 1,0,0,0,  1, 1,101,1,1,0);
        add(0, 1,0,0,0,  1, 2,102,1,1,0);
        add(0, 1,0,0,0,  1, 3,103,1,1,0);
        // Back-pressure: queue saturates at 4, then drains in order.
        add(1, 0,0,0,0,  0, 0,  0,0,1,0);
        add(0, 0,0,0,0,  0, 0,  0,0,1,0);
        add(0, 0,0,0,0,  1, 0,100,1,1,0);
        add(0, 0,0,0,0,  1, 0,100,2,1,0);
        add(0, 0,0,0,0,  1, 0,100,3,0,0);
        for (int k = 0; k < 5; k++) add(0, 0,0,0,0, 1, 0,100,4,0,0);
        add(0, 1,0,0,0,  1, 0,100,4,0,0);
        add(0, 1,0,0,0,  1, 1,101,3,1,0);
        add(0, 1,0,0,0,  1, 2,102,2,1,0);
        add(0, 1,0,0,0,  1, 3,103,2,1,0);
        add(0, 1,0,0,0,  1, 4,104,2,1,0);
        // Redirect to 20 with 3 queued + one in flight, then to 30 (wrap), then halt+redirect.
        add(1, 0,0,0,0,  0, 0,  0,0,1,0);
        add(0, 0,0,0,0,  0, 0,  0,0,1,0);
        add(0, 0,0,0,0,  1, 0,100,1,1,0);
        add(0, 0,0,0,0,  1, 0,100,2,1,0);
        add(0, 1,1,20,0, 1, 0,100,3,0,0);
        add(0, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  1,20,120,1,1,0);
        add(0, 1,1,30,0, 1,21,121,1,1,0);
        add(0, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  0, 0,  0,0,1,0);
        add(0, 1,0,0,0,  1,30,130,1,1,0);
        add(0, 1,0,0,0,  1,31,131,1,1,0);
        add(0, 1,0,0,0,  1, 0,100,1,1,0);
        add(0, 1,0,0,0,  1, 1,101,1,1,0);
        add(0, 1,1,9,1,  1, 2,102,1,1,0);
        add(0, 1,1,9,0,  0, 0,  0,0,0,1);
        add(0, 1,0,0,0,  0, 0,  0,0,0,1);
        add(0, 1,1,5,0,  0, 0,  0,0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].first) do_reset();
            drive(1'b0, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].hr);
            #1;
            chk("out_valid",   i, 32'(out_valid),   32'(vecs[i].ev));
            chk("out_pc",      i, 32'(out_pc),      32'(vecs[i].epc));
            chk("out_instr",   i, out_instr,        vecs[i].ei);
            chk("queue_count", i, 32'(queue_count), 32'(vecs[i].ec));
            chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].ereq));
            chk("halted",      i, 32'(halted),      32'(vecs[i].eh));
            tick();
        end

        // Halted: PC frozen at 4 (halt beat the redirect), redirects ignored.
        drive(1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        #1;
        chk("halt_addr", 100, 32'(imem_addr), 32'd4);
        chk("halt_req_out", 100, 32'(imem_req), 32'd0);
        tick();
        chk("halt_addr2", 101, 32'(imem_addr), 32'd4);
        chk("halt_sticky", 101, 32'(halted), 32'd1);

        // Reset releases the halt and restarts at RESET_PC.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("restart_req", 102, 32'(imem_req), 32'd1);
        chk("restart_addr", 102, 32'(imem_addr), 32'd0);
        tick();
        tick();
        chk("restart_valid", 103, 32'(out_valid), 32'd1);
        chk("restart_pc", 103, 32'(out_pc), 32'd0);

        // Mid-run reset with 3 queued and one word in flight: nothing stale survives.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) tick();
        chk("pre_rst_count", 104, 32'(queue_count), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("mid_rst_count", 105, 32'(queue_count), 32'd0);
        chk("mid_rst_valid", 105, 32'(out_valid), 32'd0);
        chk("mid_rst_addr", 105, 32'(imem_addr), 32'd0);
        tick();
        chk("no_stale_push", 106, 32'(queue_count), 32'd0);
        tick();
        chk("post_rst_count", 107, 32'(queue_count), 32'd1);
        chk("post_rst_pc", 107, 32'(out_pc), 32'd0);

        // Reset with the queue full.
        repeat (4) tick();
        chk("full_count", 108, 32'(queue_count), 32'd4);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("full_rst_count", 109, 32'(queue_count), 32'd0);
        chk("full_rst_valid", 109, 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
